// File: rtl/dds_wave_lut_if.sv
// Sample-path bundle between the phase accumulator, this LUT stage and the DAC:
// phase and selection requests in, amplitude sample and its valid flag out.
`timescale 1ns/1ps
interface dds_wave_lut_if;
  logic [7:0] acc_sum;
  logic [1:0] wave_sel;
  logic [1:0] amp_sel;
  logic [7:0] wave_out;
  logic       out_valid;

  modport master (
    output acc_sum, wave_sel, amp_sel,
    input  wave_out, out_valid
  );

  modport slave (
    input  acc_sum, wave_sel, amp_sel,
    output wave_out, out_valid
  );
endinterface

// File: rtl/dds_wave_lut.sv
// DDS phase-to-amplitude stage: 3-stage pipeline mapping an 8-bit phase to a
// sine/triangle/sawtooth/square sample, with selections latched only at phase wraps.
`timescale 1ns/1ps
module dds_wave_lut (
  input logic           clk_100kHz,
  input logic           rst_,
  dds_wave_lut_if.slave bus
);

  // First quadrant of round(127*sin(2*pi*(k+0.5)/256)); half-step offset keeps it symmetric.
  function automatic logic [6:0] sine_quarter(input logic [5:0] k);
    logic [6:0] t;
    case (k)
      6'd0:  t = 7'd2;   6'd1:  t = 7'd5;   6'd2:  t = 7'd8;   6'd3:  t = 7'd11;
      6'd4:  t = 7'd14;  6'd5:  t = 7'd17;  6'd6:  t = 7'd20;  6'd7:  t = 7'd23;
      6'd8:  t = 7'd26;  6'd9:  t = 7'd29;  6'd10: t = 7'd32;  6'd11: t = 7'd35;
      6'd12: t = 7'd38;  6'd13: t = 7'd41;  6'd14: t = 7'd44;  6'd15: t = 7'd47;
      6'd16: t = 7'd50;  6'd17: t = 7'd53;  6'd18: t = 7'd56;  6'd19: t = 7'd58;
      6'd20: t = 7'd61;  6'd21: t = 7'd64;  6'd22: t = 7'd67;  6'd23: t = 7'd69;
      6'd24: t = 7'd72;  6'd25: t = 7'd74;  6'd26: t = 7'd77;  6'd27: t = 7'd79;
      6'd28: t = 7'd82;  6'd29: t = 7'd84;  6'd30: t = 7'd86;  6'd31: t = 7'd89;
      6'd32: t = 7'd91;  6'd33: t = 7'd93;  6'd34: t = 7'd95;  6'd35: t = 7'd97;
      6'd36: t = 7'd99;  6'd37: t = 7'd101; 6'd38: t = 7'd103; 6'd39: t = 7'd105;
      6'd40: t = 7'd106; 6'd41: t = 7'd108; 6'd42: t = 7'd110; 6'd43: t = 7'd111;
      6'd44: t = 7'd113; 6'd45: t = 7'd114; 6'd46: t = 7'd115; 6'd47: t = 7'd117;
      6'd48: t = 7'd118; 6'd49: t = 7'd119; 6'd50: t = 7'd120; 6'd51: t = 7'd121;
      6'd52: t = 7'd122; 6'd53: t = 7'd123; 6'd54: t = 7'd124; 6'd55: t = 7'd124;
      6'd56: t = 7'd125; 6'd57: t = 7'd125; 6'd58: t = 7'd126; 6'd59: t = 7'd126;
      6'd60: t = 7'd127; 6'd61: t = 7'd127; 6'd62: t = 7'd127; 6'd63: t = 7'd127;
      default: t = 7'd127;
    endcase
    return t;
  endfunction

  logic [7:0]        ph_prev_r;
  logic              first_r;
  logic [1:0]        wave_act_r;
  logic [1:0]        amp_act_r;
  logic [7:0]        cnt_r;
  logic [7:0]        p1_r;
  logic [1:0]        w1_r;
  logic [1:0]        a1_r;
  logic [7:0]        x_r;
  logic [1:0]        a2_r;
  logic [7:0]        wave_out_r;
  logic [1:0]        vld_r;
  logic              out_valid_r;

  logic              wrap_s;
  logic              update_s;
  logic [5:0]        quarter_idx_s;
  logic [6:0]        sine_mag_s;
  logic [7:0]        x_next_s;
  logic signed [8:0] d_s;
  logic signed [8:0] sh_s;
  logic [7:0]        out_next_s;

  // A strict phase decrease is a wrap; the counter forces an update when the phase stalls.
  assign wrap_s   = first_r | (bus.acc_sum < ph_prev_r);
  assign update_s = wrap_s | (cnt_r == 8'd255);

  // Selection control: latch requested waveform/amplitude only on update.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      ph_prev_r  <= 8'd0;
      first_r    <= 1'b1;
      wave_act_r <= 2'b00;
      amp_act_r  <= 2'b00;
      cnt_r      <= 8'd0;
    end else begin
      ph_prev_r <= bus.acc_sum;
      first_r   <= 1'b0;
      if (update_s) begin
        wave_act_r <= bus.wave_sel;
        amp_act_r  <= bus.amp_sel;
        cnt_r      <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Stage 1: capture phase with the selection that governs this sample.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      p1_r <= 8'd0;
      w1_r <= 2'b00;
      a1_r <= 2'b00;
    end else begin
      p1_r <= bus.acc_sum;
      w1_r <= update_s ? bus.wave_sel : wave_act_r;
      a1_r <= update_s ? bus.amp_sel : amp_act_r;
    end
  end

  // Waveform shaping; 63-k in the mirrored quadrants is the bitwise complement of k.
  always_comb begin
    quarter_idx_s = p1_r[6] ? ~p1_r[5:0] : p1_r[5:0];
    sine_mag_s    = sine_quarter(quarter_idx_s);
    case (w1_r)
      2'b00:   x_next_s = p1_r[7] ? (8'd128 - {1'b0, sine_mag_s}) : (8'd128 + {1'b0, sine_mag_s});
      2'b01:   x_next_s = p1_r[7] ? {~p1_r[6:0], 1'b0} : {p1_r[6:0], 1'b0};
      2'b10:   x_next_s = p1_r;
      2'b11:   x_next_s = p1_r[7] ? 8'd0 : 8'd255;
      default: x_next_s = 8'd128;
    endcase
  end

  // Stage 2: register waveform value and carry amplitude select.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      x_r  <= 8'd128;
      a2_r <= 2'b00;
    end else begin
      x_r  <= x_next_s;
      a2_r <= a1_r;
    end
  end

  // Amplitude scaling about midscale via arithmetic shift of the signed offset.
  assign d_s        = $signed({1'b0, x_r}) - 9'sd128;
  assign sh_s       = d_s >>> a2_r;
  assign out_next_s = 8'd128 + sh_s[7:0];

  // Stage 3: output sample and valid pipeline.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      wave_out_r  <= 8'd128;
      vld_r       <= 2'b00;
      out_valid_r <= 1'b0;
    end else begin
      wave_out_r  <= out_next_s;
      vld_r       <= {vld_r[0], 1'b1};
      out_valid_r <= vld_r[1];
    end
  end

  assign bus.wave_out  = wave_out_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: doc/dds_wave_lut.md
# dds_wave_lut

Phase-to-amplitude stage of the DDS chain, directly downstream of the phase accumulator. It consumes the 8-bit accumulator phase `acc_sum` and produces an 8-bit unsigned sample for the DAC. Four waveforms are selectable: sine via a quarter-wave table, triangle, sawtooth and square. Four amplitude levels are selectable. Waveform and amplitude changes are applied glitch-free, only at a phase wrap.

## Interface
- No parameters. Phase and sample widths are fixed at 8 bits to match the accumulator.
- `clk_100kHz`  in  1  system clock; all registers update on the rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `acc_sum`  in  8  phase from the accumulator; sampled every clock.
- `wave_sel`  in  2  waveform request: 00 sine, 01 triangle, 10 sawtooth, 11 square.
- `amp_sel`  in  2  amplitude request: 00 full, 01 half, 10 quarter, 11 eighth.
- `wave_out`  out  8  unsigned sample, midscale 128, registered.
- `out_valid`  out  1  high once the pipeline holds real samples, registered.

## Operation
- **Selection control**
  - Registers: `ph_prev[7:0]`, `first`, `wave_act[1:0]`, `amp_act[1:0]`, `cnt[7:0]`.
  - `wrap = first | (acc_sum < ph_prev)`, unsigned compare.
  - `update = wrap | (cnt == 255)`.
  - Every edge: `ph_prev <= acc_sum` and `first <= 0`.
  - On `update`: `wave_act <= wave_sel`, `amp_act <= amp_sel`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - The timeout guarantees a selection change is applied within 256 cycles even when `freq_ctrl = 0` (the phase never wraps).
- **Request changes**
  - `wave_sel`/`amp_sel` changes between updates are invisible; only the value present at the update edge matters.
  - When `wrap` and the timeout coincide, there is a single update.
- **Stage 1, edge n**
  - `p1 <= acc_sum`.
  - `{w1,a1} <= update ? {wave_sel,amp_sel} : {wave_act,amp_act}`.
  - The new selection applies from the wrapping sample itself.
- **Stage 2, edge n+1: waveform value `x`**
  - Sine, with table `T[k] = round(127*sin(2π(k+0.5)/256))` for k = 0..63 (values 2..127, 7 bits, constant ROM). By quadrant `p1[7:6]`:
    - 00: `128+T[p1[5:0]]`
    - 01: `128+T[63-p1[5:0]]`
    - 10: `128-T[p1[5:0]]`
    - 11: `128-T[63-p1[5:0]]`
  - Sine range is 1..255; no saturation is needed.
  - Triangle: `p1<128 ? 2*p1 : 2*(255-p1)`, range 0..254.
  - Sawtooth: `p1`.
  - Square: `p1[7] ? 0 : 255`.
  - `a1` is carried forward as `a2`.
- **Stage 3, edge n+2: amplitude**
  - `d = x - 128` as 9-bit signed.
  - `wave_out <= 128 + (d >>> a2)`, arithmetic shift, truncated to 8 bits.
  - Result ranges: full 0..255, half 64..191, quarter 96..159, eighth 112..143.
- **Valid pipeline**
  - Two-bit valid shift register feeding `out_valid`; it fills with 1s after reset release.
  - `out_valid` first goes high at edge 2 after reset release (edges counted from 0).

## Timing
- Latency is three register stages: the `acc_sum` value sampled at edge n appears on `wave_out` after edge n+2.
- Throughput is one sample per clock; there is no stall or backpressure.
- **Reset (async, immediate)**
  - Outputs: `wave_out = 128`, `out_valid = 0`.
  - Control: `first = 1`, `cnt = 0`, `wave_act = 00`, `amp_act = 00`, `ph_prev = 0`.
  - Pipeline registers: cleared; stage-2 value set to 128.
- **Reset mid-operation**
  - Outputs return to reset values at once; the pipeline is discarded.
  - After release, the selection inputs are re-latched at the first edge (`first = 1`).
- **Phase wrap**
  - Detected only as a strict decrease. Example: `freq_ctrl = 16` gives 240→0, which is a wrap.
  - Equal consecutive phases are not a wrap.

## Test plan
- **Reset:** hold `rst_` low → `wave_out = 128`, `out_valid = 0`. Release with `acc_sum = 0`, sine, full → after edge 2, `wave_out = 130`, `out_valid = 1`.
- **Sine, quadrant symmetry:** `freq_ctrl = 1`, phases 0/64/128/192 → `wave_out` 130/255/126/1, each 3 edges after its phase is sampled.
- **Other waveforms:** phase 127 → triangle 254, sawtooth 127, square 255. Phase 200 → triangle 110, sawtooth 200, square 0.
- **Amplitude:** square, `amp_sel = 01` → alternates 191/64. `amp_sel = 11` → 143/112.
- **Glitch-free switch:** `freq_ctrl = 16`, change sine→square while phase = 80 → samples for phases 80..240 remain sine. The sample for phase 0 (after 240→0) is 255, appearing 3 edges after phase 0 is sampled.
- **Timeout and async reset:** `freq_ctrl = 0`, phase fixed at 64, sine. Switch to sawtooth → `wave_out` changes 255→64 within 256+3 cycles. Then assert `rst_` mid-stream → `wave_out = 128` immediately.
